// File: rtl/acc_mem_pkg.sv
// Shared types and sizes for the accelerator memory arbiter.
package acc_mem_pkg;

  localparam int N_ACC_DEF          = 4;
  localparam int ADDR_SIZE_DEF      = 16;
  localparam int RD_DATA_SIZE_DEF   = 512;
  localparam int WR_DATA_SIZE_DEF   = 32;
  localparam int MEM_RD_LATENCY_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } arb_state_t;

  // Low bit of client idx's field in a packed per-client vector.
  function automatic int slice(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/acc_rr_picker.sv
// Combinational round-robin search: first requester at or above rr_ptr, wrapping.
module acc_rr_picker #(
  parameter  int N_ACC = 4,
  localparam int IW    = $clog2(N_ACC)
) (
  input  logic [N_ACC-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             any_req,
  output logic [IW-1:0]    grant_idx
);

  int            c;
  logic [IW-1:0] ci;

  // Walk from farthest to nearest so the closest requester is the last writer.
  always_comb begin
    any_req   = |req;
    grant_idx = '0;
    c         = 0;
    ci        = '0;
    for (int k = N_ACC - 1; k >= 0; k--) begin
      c = int'(rr_ptr) + k;
      if (c >= N_ACC) c = c - N_ACC;
      ci = IW'(c);
      if (req[ci]) grant_idx = ci;
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter granting one accelerator read/write at a time onto a
// single data-memory port; the CPU preempts issue through cpu_mem_busy.
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int N_ACC          = N_ACC_DEF,
  parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int RD_DATA_SIZE   = RD_DATA_SIZE_DEF,
  parameter int WR_DATA_SIZE   = WR_DATA_SIZE_DEF,
  parameter int MEM_RD_LATENCY = MEM_RD_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_ACC-1:0]              acc_read_en,
  input  logic [N_ACC*ADDR_SIZE-1:0]    acc_read_addr,
  input  logic [N_ACC-1:0]              acc_write_en,
  input  logic [N_ACC*ADDR_SIZE-1:0]    acc_write_addr,
  input  logic [N_ACC*WR_DATA_SIZE-1:0] acc_write_data,
  output logic [RD_DATA_SIZE-1:0]       acc_read_data,
  output logic [N_ACC-1:0]              acc_read_data_valid,
  output logic [N_ACC-1:0]              acc_write_done,
  input  logic                          cpu_mem_busy,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [ADDR_SIZE-1:0]          mem_addr,
  output logic [WR_DATA_SIZE-1:0]       mem_wr_data,
  input  logic [RD_DATA_SIZE-1:0]       mem_rd_data
);

  localparam int IW = $clog2(N_ACC);
  localparam int CW = 4;

  arb_state_t              state;
  logic [IW-1:0]           idx, rr_ptr, grant_idx;
  logic                    any_req;
  logic [ADDR_SIZE-1:0]    addr_q, rd_addr_sel, wr_addr_sel;
  logic [WR_DATA_SIZE-1:0] wdata_q, wr_data_sel;
  logic [CW-1:0]           cnt;
  logic [N_ACC-1:0]        idx_hot;

  acc_rr_picker #(.N_ACC(N_ACC)) u_picker (
    .req       (acc_read_en | acc_write_en),
    .rr_ptr    (rr_ptr),
    .any_req   (any_req),
    .grant_idx (grant_idx)
  );

  assign rd_addr_sel = acc_read_addr[slice(int'(grant_idx), ADDR_SIZE) +: ADDR_SIZE];
  assign wr_addr_sel = acc_write_addr[slice(int'(grant_idx), ADDR_SIZE) +: ADDR_SIZE];
  assign wr_data_sel = acc_write_data[slice(int'(grant_idx), WR_DATA_SIZE) +: WR_DATA_SIZE];
  assign idx_hot     = N_ACC'(1) << idx;

  // Strobes gate on the live busy flag so they never overlap a CPU cycle.
  assign mem_rd_en   = (state == RD_ISSUE) && !cpu_mem_busy;
  assign mem_wr_en   = (state == WR_ISSUE) && !cpu_mem_busy;
  assign mem_addr    = (mem_rd_en || mem_wr_en) ? addr_q : '0;
  assign mem_wr_data = mem_wr_en ? wdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      idx                 <= '0;
      rr_ptr              <= '0;
      addr_q              <= '0;
      wdata_q             <= '0;
      cnt                 <= '0;
      acc_read_data       <= '0;
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;
    end else begin
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;
      case (state)
        IDLE: if (any_req) begin
          idx     <= grant_idx;
          wdata_q <= wr_data_sel;
          // A client asking for both gets its write first; the read stays pending.
          if (acc_write_en[grant_idx]) begin
            addr_q <= wr_addr_sel;
            state  <= WR_ISSUE;
          end else begin
            addr_q <= rd_addr_sel;
            state  <= RD_ISSUE;
          end
        end
        RD_ISSUE: if (!cpu_mem_busy) begin
          cnt   <= CW'(MEM_RD_LATENCY);
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            acc_read_data       <= mem_rd_data;
            acc_read_data_valid <= idx_hot;
            state               <= DONE;
          end
        end
        WR_ISSUE: if (!cpu_mem_busy) begin
          acc_write_done <= idx_hot;
          state          <= DONE;
        end
        DONE: begin
          rr_ptr <= (idx == IW'(N_ACC - 1)) ? '0 : idx + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_mem_arbiter.md
# acc_mem_arbiter

Shared-memory arbiter serving the accelerator-side read and write request ports of `N_ACC` hashing accelerator control units. It is the responder end of the accelerator memory handshake. It grants one request at a time in round-robin order and drives a single data-memory port. It returns either a full 512-bit read line with a one-cycle `acc_read_data_valid` pulse, or a one-cycle `acc_write_done` pulse. The CPU keeps priority on the memory port through `cpu_mem_busy`.

## Interface
- `N_ACC`, 4: number of accelerator clients (≥2)
- `ADDR_SIZE`, 16: memory address width
- `RD_DATA_SIZE`, 512: read line width
- `WR_DATA_SIZE`, 32: write word width
- `MEM_RD_LATENCY`, 1: cycles from `mem_rd_en` to valid `mem_rd_data` (1..15)

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `acc_read_en` in N_ACC: per-client read request, held until the client sees its valid pulse
- `acc_read_addr` in N_ACC*ADDR_SIZE: packed read addresses; client i occupies slice i
- `acc_write_en` in N_ACC: per-client write request, held until done
- `acc_write_addr` in N_ACC*ADDR_SIZE: packed write addresses
- `acc_write_data` in N_ACC*WR_DATA_SIZE: packed write words
- `acc_read_data` out RD_DATA_SIZE: last captured read line, broadcast to all clients
- `acc_read_data_valid` out N_ACC: one-hot, one-cycle pulse to the granted reader
- `acc_write_done` out N_ACC: one-hot, one-cycle pulse to the granted writer
- `cpu_mem_busy` in 1: CPU owns the memory port this cycle; the arbiter must not issue
- `mem_rd_en` out 1: memory read strobe
- `mem_wr_en` out 1: memory write strobe
- `mem_addr` out ADDR_SIZE: memory address
- `mem_wr_data` out WR_DATA_SIZE: memory write data
- `mem_rd_data` in RD_DATA_SIZE: memory read line

## Operation

**States:** IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.

**IDLE**
- Pick the first client with `acc_read_en | acc_write_en`, searching from `rr_ptr` upward and wrapping at N_ACC-1 to 0.
- Latch the client index, op, address and write data.
- Go to RD_ISSUE or WR_ISSUE. Stay in IDLE if no requests.
- If a client asserts both read and write, the write is granted. The read stays pending for a later grant.

**RD_ISSUE**
- Drive `mem_addr` from the latched address.
- Assert `mem_rd_en` only when `!cpu_mem_busy`; otherwise stall in RD_ISSUE.
- On issue, load the latency counter with MEM_RD_LATENCY and go to RD_WAIT.

**RD_WAIT**
- Decrement the counter each cycle.
- When the counter reaches 1, capture `mem_rd_data` into `acc_read_data` and go to DONE.

**WR_ISSUE**
- Drive `mem_addr` and `mem_wr_data` from the latched values.
- Assert `mem_wr_en` only when `!cpu_mem_busy`; otherwise stall.
- On issue, go to DONE.

**DONE**
- Pulse `acc_read_data_valid[idx]` or `acc_write_done[idx]` for exactly one cycle.
- Set `rr_ptr` = idx+1 mod N_ACC.
- Go to IDLE.

**Request handling rules**
- Requests are only sampled in IDLE. Changes to a granted client's inputs after the latch are ignored.
- A client drops or changes its request the cycle after its pulse. IDLE therefore never sees a stale copy of a completed request.
- `acc_read_data` holds its value until the next read capture.
- `mem_*` outputs are 0 in every state where they are not asserted.

## Timing
- **Reset:** any time, including mid-operation, reset forces IDLE, `rr_ptr`=0, counter=0 and all outputs 0, `acc_read_data` included. An in-flight op is dropped with no pulse.
- **Read, no stall:** request seen in IDLE at cycle 0 → `mem_rd_en` at cycle 1 → valid pulse at cycle 2+MEM_RD_LATENCY → IDLE again at cycle 3+MEM_RD_LATENCY.
- **Write, no stall:** request at cycle 0 → `mem_wr_en` at cycle 1 → done pulse at cycle 2 → IDLE at cycle 3.
- **CPU stall:** each `cpu_mem_busy` cycle in an ISSUE state adds exactly one cycle.
- **Throughput:** one op at most per 3 cycles for writes, per 3+MEM_RD_LATENCY cycles for reads.
- **Fairness:** with all clients requesting, grants cycle 0,1,…,N_ACC-1,0. A continuously requesting client waits at most N_ACC-1 ops.

## Structure
- Package `acc_mem_pkg` contains:
  - the `arb_state_t` enum (5 states)
  - the default sizes
  - a `slice` helper for the packed per-client vectors
- Sub-module `acc_rr_picker`: combinational round-robin priority search. Inputs are the request vector and `rr_ptr`; outputs are `any_req` and `grant_idx`.
- The top level holds:
  - the FSM
  - the latch registers
  - the latency counter
  - `rr_ptr`
  - the read-data register

## Test plan
- **Single read:** client 2 reads 0x1000, `mem_rd_data`=pattern A, latency 1 → `mem_rd_en` with `mem_addr`=0x1000 at cycle 1; `acc_read_data`=A and `acc_read_data_valid`=4'b0100 at cycle 3.
- **Single write:** client 0 writes 0x00000005 to 0x5000 → `mem_wr_en`, `mem_addr`=0x5000, `mem_wr_data`=5 at cycle 1; `acc_write_done`=4'b0001 at cycle 2.
- **Round-robin:** all 4 clients request writes continuously → done pulses to 0,1,2,3,0 every 3 cycles; no client is granted twice in a row.
- **CPU stall:** `cpu_mem_busy` high for 3 cycles during RD_ISSUE, latency 4 → valid pulse at cycle 9; `mem_rd_en` never coincides with `cpu_mem_busy`.
- **Reset mid-read:** assert `rst_n`=0 in RD_WAIT → all outputs 0 immediately and no pulse. After release with client 1 requesting, client 1 is granted from `rr_ptr`=0.
- **Simultaneous read and write from client 3** → write done first; the read is granted on a later round and returns the line just written.
